mem_wb_stage: RTL

Memory stage of the 5-stage pipeline, placed directly downstream of the EX/MEM register. It consumes the EX/MEM outputs, performs data-memory loads and stores with a configurable number of wait states, and resolves the branch decision. It stalls the upstream pipeline while an access is in progress and registers results into the MEM/WB pipeline register that feeds write-back.

---
 rtl/mem_wb_stage.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_wb_stage: data-memory access with wait states, branch resolve, MEM/WB |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mem_wb_stage #(
  parameter int DWL  = 32,
  parameter int AWL  = 8,
  parameter int WAIT = 2
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           RFWEM,
  input  logic           MtoRFSelM,
  input  logic           DMWEM,
  input  logic           BranchM,
  input  logic           ZeroM,
  input  logic [4:0]     rtdM,
  input  logic [DWL-1:0] ALUOutM,
  input  logic [DWL-1:0] DMdinM,
  input  logic [DWL-1:0] PCBranchM,
  output logic           PCSrcM,
  output logic [DWL-1:0] PCBranchF,
  output logic           StallM,
  output logic           RFWEW,
  output logic           MtoRFSelW,
  output logic [4:0]     rtdW,
  output logic [DWL-1:0] ALUOutW,
  output logic [DWL-1:0] DMoutW
);

  localparam logic [3:0] c_WAIT = 4'(WAIT);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [DWL-1:0]   r_mem [0:(1<<AWL)-1];

  logic             r_rfwe;
  logic             r_mtorf;
  logic [4:0]       r_rtd;
  logic [DWL-1:0]   r_alu;
  logic [DWL-1:0]   r_dmout;

  logic             w_access;
  logic             w_stall;
  logic [AWL-1:0]   w_addr;

  assign w_access = MtoRFSelM | DMWEM;
  assign w_addr   = ALUOutM[AWL+1:2];

  // Stall is combinational so upstream freezes in the same cycle the access appears.
  always_comb begin
    w_stall = 1'b0;
    if (!RST) begin
      case (r_state)
        S_IDLE:  w_stall = w_access && (c_WAIT != 4'd0);
        S_BUSY:  w_stall = (r_cnt != c_WAIT);
        default: w_stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_rfwe  <= 1'b0;
      r_mtorf <= 1'b0;
      r_rtd   <= 5'd0;
      r_alu   <= '0;
      r_dmout <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_stall) begin
            r_state <= S_BUSY;
            r_cnt   <= 4'd1;
          end
        end
        S_BUSY: begin
          if (w_stall) begin
            r_cnt <= r_cnt + 4'd1;
          end else begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 4'd0;
        end
      endcase

      // A stall inserts a bubble; payload fields hold their last values.
      if (w_stall) begin
        r_rfwe  <= 1'b0;
        r_mtorf <= 1'b0;
      end else begin
        r_rfwe  <= RFWEM;
        r_mtorf <= MtoRFSelM;
        r_rtd   <= rtdM;
        r_alu   <= ALUOutM;
        r_dmout <= r_mem[w_addr];
      end
    end
  end

  // Array is not reset; a store is abandoned if reset is high at the closing edge.
  always_ff @(posedge CLK) begin
    if (!RST && !w_stall && DMWEM) begin
      r_mem[w_addr] <= DMdinM;
    end
  end

  assign PCSrcM    = BranchM & ZeroM;
  assign PCBranchF = PCBranchM;
  assign StallM    = w_stall;
  assign RFWEW     = r_rfwe;
  assign MtoRFSelW = r_mtorf;
  assign rtdW      = r_rtd;
  assign ALUOutW   = r_alu;
  assign DMoutW    = r_dmout;

endmodule
`default_nettype wire
